// File: rtl/systolic_array_2_by_2.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_2_by_2
// Function : 2x2 output-stationary MAC array computing a valid-mode 2-D
//            convolution of a 4x4 matrix with a rotated 3x3 kernel, mod 256.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_2_by_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       active_sa2,
  input  logic [7:0] a11, a12, a13, a14,
  input  logic [7:0] a21, a22, a23, a24,
  input  logic [7:0] a31, a32, a33, a34,
  input  logic [7:0] a41, a42, a43, a44,
  input  logic [7:0] b11, b12, b13,
  input  logic [7:0] b21, b22, b23,
  input  logic [7:0] b31, b32, b33,
  output logic       done_sa2,
  output logic [7:0] c11, c12, c21, c22
);

  localparam logic [3:0] C_LAST_STEP = 4'd8;
  localparam logic [3:0] C_OUT_COUNT = 4'd11;
  localparam logic [3:0] C_SAT_COUNT = 4'd12;

  logic [7:0] w_a [4][4];
  logic [7:0] w_b [3][3];
  logic [3:0] r_count;

  always_comb begin
    w_a[0] = '{a11, a12, a13, a14};
    w_a[1] = '{a21, a22, a23, a24};
    w_a[2] = '{a31, a32, a33, a34};
    w_a[3] = '{a41, a42, a43, a44};
    w_b[0] = '{b11, b12, b13};
    w_b[1] = '{b21, b22, b23};
    w_b[2] = '{b31, b32, b33};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!active_sa2) begin
      r_count <= '0;
    end else if (r_count != C_SAT_COUNT) begin
      r_count <= r_count + 4'd1;
    end
  end

  // Each PE lags PE(0,0) by r+c cycles, so its local step is count-(r+c).
  for (genvar R = 0; R < 2; R++) begin : g_row
    for (genvar C = 0; C < 2; C++) begin : g_col
      logic [3:0] w_k;
      logic       w_en;
      logic [1:0] w_p, w_q;
      logic [1:0] w_ar, w_ac;
      logic [7:0] w_prod;
      logic [7:0] r_acc;

      always_comb begin
        w_k  = r_count - 4'(R + C);
        w_en = active_sa2 && (r_count >= 4'(R + C)) && (w_k <= C_LAST_STEP);
        w_p  = 2'd0;
        w_q  = 2'd0;
        case (w_k)
          4'd1: w_q = 2'd1;
          4'd2: w_q = 2'd2;
          4'd3: w_p = 2'd1;
          4'd4: begin w_p = 2'd1; w_q = 2'd1; end
          4'd5: begin w_p = 2'd1; w_q = 2'd2; end
          4'd6: w_p = 2'd2;
          4'd7: begin w_p = 2'd2; w_q = 2'd1; end
          4'd8: begin w_p = 2'd2; w_q = 2'd2; end
          default: ;
        endcase
        w_ar   = 2'(R) + w_p;
        w_ac   = 2'(C) + w_q;
        w_prod = w_a[w_ar][w_ac] * w_b[2'd2 - w_p][2'd2 - w_q];
      end

      // Step 0 loads rather than adds, flushing any previous run.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc <= '0;
        end else if (w_en) begin
          r_acc <= (w_k == 4'd0) ? w_prod : r_acc + w_prod;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_sa2 <= 1'b0;
      c11      <= '0;
      c12      <= '0;
      c21      <= '0;
      c22      <= '0;
    end else if (!active_sa2) begin
      done_sa2 <= 1'b0;
    end else if (r_count == C_OUT_COUNT) begin
      done_sa2 <= 1'b1;
      c11      <= g_row[0].g_col[0].r_acc;
      c12      <= g_row[0].g_col[1].r_acc;
      c21      <= g_row[1].g_col[0].r_acc;
      c22      <= g_row[1].g_col[1].r_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_2_by_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_2_by_2
// Function : Directed self-checking bench for systolic_array_2_by_2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_2_by_2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active_sa2 = 1'b0;
  logic [7:0] a [4][4];
  logic [7:0] b [3][3];
  logic       done_sa2;
  logic [7:0] c11, c12, c21, c22;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  systolic_array_2_by_2 dut (
    .clk(clk), .rst(rst), .active_sa2(active_sa2),
    .a11(a[0][0]), .a12(a[0][1]), .a13(a[0][2]), .a14(a[0][3]),
    .a21(a[1][0]), .a22(a[1][1]), .a23(a[1][2]), .a24(a[1][3]),
    .a31(a[2][0]), .a32(a[2][1]), .a33(a[2][2]), .a34(a[2][3]),
    .a41(a[3][0]), .a42(a[3][1]), .a43(a[3][2]), .a44(a[3][3]),
    .b11(b[0][0]), .b12(b[0][1]), .b13(b[0][2]),
    .b21(b[1][0]), .b22(b[1][1]), .b23(b[1][2]),
    .b31(b[2][0]), .b32(b[2][1]), .b33(b[2][2]),
    .done_sa2(done_sa2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22)
  );

  // Reference convolution, packed as {c22, c21, c12, c11}.
  function automatic logic [31:0] model();
    logic [7:0] acc;
    logic [7:0] prod;
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        acc = '0;
        for (int p = 0; p < 3; p++)
          for (int q = 0; q < 3; q++) begin
            prod = a[r+p][c+q] * b[2-p][2-q];
            acc  = acc + prod;
          end
        res[(r*2+c)*8 +: 8] = acc;
      end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_c(input string tag, input logic [31:0] exp);
    chk({tag, "_c11"}, c11, exp[7:0]);
    chk({tag, "_c12"}, c12, exp[15:8]);
    chk({tag, "_c21"}, c21, exp[23:16]);
    chk({tag, "_c22"}, c22, exp[31:24]);
  endtask

  task automatic load_a_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a[r][c] = 8'(r*4 + c + 1);
  endtask

  task automatic load_b_ramp();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) b[r][c] = 8'(r*3 + c + 1);
  endtask

  task automatic load_b_const(input logic [7:0] v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) b[r][c] = v;
  endtask

  // Raise active at a negedge, expect done on the 12th rising edge, hold,
  // then optionally drop active and confirm done clears while c holds.
  task automatic run(input string tag, input logic [31:0] exp, input int hold, input bit drop);
    int edges;
    logic [31:0] got;
    sb.push_back(exp);
    active_sa2 = 1'b1;
    edges = 0;
    while (!done_sa2 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, 8'(edges), 8'd12);
    chk({tag, "_done"}, {7'b0, done_sa2}, 8'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd0, 8'd1);
      got = '0;
    end else begin
      got = sb.pop_front();
    end
    check_c(tag, got);
    repeat (hold) @(negedge clk);
    chk({tag, "_done_hold"}, {7'b0, done_sa2}, 8'd1);
    check_c({tag, "_hold"}, got);
    if (drop) begin
      active_sa2 = 1'b0;
      @(negedge clk);
      chk({tag, "_done_fall"}, {7'b0, done_sa2}, 8'd0);
      check_c({tag, "_after"}, got);
    end
  endtask

  initial begin
    load_a_ramp();
    load_b_ramp();
    #1;
    chk("reset_done", {7'b0, done_sa2}, 8'd0);
    check_c("reset", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal: 12 edges to done, 17 more held high = 29 active cycles.
    run("nominal", {8'd161, 8'd116, 8'd237, 8'd192}, 17, 1'b1);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a[r][c] = 8'hFF;
    load_b_const(8'hFF);
    run("wrap", {8'd9, 8'd9, 8'd9, 8'd9}, 2, 1'b1);

    load_a_ramp();
    load_b_const(8'd0);
    b[1][1] = 8'd1;
    run("ident", {8'd11, 8'd10, 8'd7, 8'd6}, 1, 1'b1);

    // Abort after 5 active cycles with different data.
    load_b_ramp();
    active_sa2 = 1'b1;
    repeat (5) @(negedge clk);
    active_sa2 = 1'b0;
    @(negedge clk);
    chk("abort_done", {7'b0, done_sa2}, 8'd0);
    check_c("abort", {8'd11, 8'd10, 8'd7, 8'd6});
    repeat (3) @(negedge clk);
    chk("abort_done_late", {7'b0, done_sa2}, 8'd0);
    run("after_abort", model(), 1, 1'b1);

    // Reset at counter = 6: outputs must clear before any clock edge.
    active_sa2 = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_done", {7'b0, done_sa2}, 8'd0);
    check_c("midrst", 32'd0);
    active_sa2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: a single low cycle then a zero-kernel run.
    run("b2b_first", {8'd161, 8'd116, 8'd237, 8'd192}, 1, 1'b0);
    load_b_const(8'd0);
    active_sa2 = 1'b0;
    @(negedge clk);
    chk("b2b_gap_done", {7'b0, done_sa2}, 8'd0);
    run("b2b_zero", model(), 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
